// File: rtl/mux_seq_pkg.sv
// mux_seq_pkg: shared types and constants for the mux16 select sequencer.
package mux_seq_pkg;

   localparam int unsigned SEL_W_DEF = 4;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Number of steps in a single sweep: every code visited once from the start value.
   function automatic int unsigned sweep_len(input int unsigned w);
      return (32'd1 << w) - 32'd1;
   endfunction

   localparam int unsigned SWEEP_LEN = sweep_len(SEL_W_DEF);

endpackage

// File: rtl/mux_sel_prescaler.sv
// mux_sel_prescaler: down-counter producing a one-cycle step tick every period+1
// enabled cycles. Period is captured and the counter loaded when clr is high.
module mux_sel_prescaler #(
   parameter int unsigned PRESCALE_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  en,
   input  logic [PRESCALE_W-1:0] period,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] period_q, period_d;
   logic [PRESCALE_W-1:0] cnt_q, cnt_d;

   assign tick = en && (cnt_q == '0);

   // Next-count: load on clear, count down while enabled, reload after a tick.
   always_comb begin
      period_d = period_q;
      cnt_d    = cnt_q;
      if (clr) begin
         period_d = period;
         cnt_d    = period;
      end else if (en) begin
         if (cnt_q == '0) begin
            cnt_d = period_q;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   // Counter and period registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         period_q <= '0;
         cnt_q    <= '0;
      end else begin
         period_q <= period_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: steps the mux16 select code up/down, single sweep or
// continuous, with busy/wrap/done status.
// Optional feature macro: MUX_SEL_PRESCALE_EN (step period = prescale+1 cycles);
// when undefined a step occurs every RUN cycle and prescale is ignored.
module mux_sel_sequencer
   import mux_seq_pkg::*;
#(
   parameter int unsigned SEL_W      = SEL_W_DEF,
   parameter int unsigned PRESCALE_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  dir,
   input  logic                  cont,
   input  logic                  load,
   input  logic [SEL_W-1:0]      load_val,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic [SEL_W-1:0]      sel,
   output logic                  busy,
   output logic                  wrap,
   output logic                  done
);

   localparam logic [SEL_W-1:0] LAST_STEP = SEL_W'(sweep_len(SEL_W));

   state_t            state_q, state_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [SEL_W-1:0]  step_q, step_d;
   logic [SEL_W-1:0]  step_inc;
   logic              dir_q, dir_d;
   logic              cont_q, cont_d;
   logic              wrap_q, wrap_d;
   logic              start_acc;
   logic              tick;

   assign start_acc = start && (state_q != ST_RUN);
   assign step_inc  = step_q + 1'b1;

`ifdef MUX_SEL_PRESCALE_EN
   mux_sel_prescaler #(
      .PRESCALE_W(PRESCALE_W)
   ) u_prescaler (
      .clk   (clk),
      .rst   (rst),
      .clr   (start_acc),
      .en    (state_q == ST_RUN),
      .period(prescale),
      .tick  (tick)
   );
`else
   logic prescale_unused;
   assign prescale_unused = ^prescale;
   assign tick = 1'b1;
`endif

   // Next-state, select stepping, wrap detection and sweep accounting.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      step_d  = step_q;
      dir_d   = dir_q;
      cont_d  = cont_q;
      wrap_d  = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (load) begin
               sel_d = load_val;
            end
            if (start) begin
               state_d = ST_RUN;
               dir_d   = dir;
               cont_d  = cont;
               step_d  = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (tick) begin
               if (dir_q == DIR_UP) begin
                  sel_d  = sel_q + 1'b1;
                  wrap_d = (sel_q == '1);
               end else begin
                  sel_d  = sel_q - 1'b1;
                  wrap_d = (sel_q == '0);
               end
               if (!cont_q) begin
                  step_d = step_inc;
                  if (step_inc == LAST_STEP) begin
                     state_d = ST_DONE;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         step_q  <= '0;
         dir_q   <= DIR_UP;
         cont_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         step_q  <= step_d;
         dir_q   <= dir_d;
         cont_q  <= cont_d;
         wrap_q  <= wrap_d;
      end
   end

   assign sel  = sel_q;
   assign wrap = wrap_q;
   assign busy = (state_q == ST_RUN);
   assign done = (state_q == ST_DONE);

endmodule
